// File: rtl/adsr_vca.sv
// ADSR envelope generator and VCA: scales each Waveform sample by a per-voice envelope.
// Optional macro EXP_RELEASE_EN selects an exponential release tail instead of a linear one.
module adsr_vca #(
  parameter int unsigned WAVE_W = 32,
  parameter int unsigned ENV_W  = 16
) (
  input  logic                     Sys_clk,
  input  logic                     Env_rst,
  input  logic                     Env_ce,
  input  logic                     Syn_clk,
  input  logic                     Gate,
  input  logic [ENV_W-1:0]         Attack_rate,
  input  logic [ENV_W-1:0]         Decay_rate,
  input  logic [ENV_W-1:0]         Sustain_level,
  input  logic [ENV_W-1:0]         Release_rate,
  input  logic signed [WAVE_W-1:0] Waveform,
  output logic signed [WAVE_W-1:0] Audio_out,
  output logic                     Out_valid,
  output logic [ENV_W-1:0]         Envelope,
  output logic                     Active
);

  localparam logic [ENV_W-1:0] FullScale = '1;
  localparam logic [ENV_W-1:0] EnvZero   = '0;

  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StDecay,
    StSustain,
    StRelease
  } state_e;

  state_e                     state_q;
  logic [ENV_W-1:0]           env_q;
  logic                       syn_q;
  logic                       gate_q;
  logic                       pend_q;
  logic                       active_q;
  logic                       out_valid_q;
  logic signed [WAVE_W-1:0]   sample_q;
  logic signed [WAVE_W-1:0]   audio_q;

  logic                       tick;
  logic                       gate_rise;

  // Per-phase step results, selected by the FSM below.
  logic [ENV_W:0]             att_sum;
  logic [ENV_W-1:0]           att_env;
  state_e                     att_st;
  logic [ENV_W-1:0]           dec_env;
  state_e                     dec_st;
  logic [ENV_W-1:0]           rel_dec;
  logic [ENV_W-1:0]           rel_env;
  state_e                     rel_st;

  logic signed [WAVE_W+ENV_W:0] prod;
  logic [WAVE_W-1:0]            audio_d;

  assign tick      = Syn_clk & ~syn_q & Env_ce;
  assign gate_rise = Gate & ~gate_q;

  always_comb begin
    att_sum = {1'b0, env_q} + {1'b0, Attack_rate};
    att_env = att_sum[ENV_W-1:0];
    att_st  = StAttack;
    if ((Attack_rate == EnvZero) || (att_sum >= {1'b0, FullScale})) begin
      att_env = FullScale;
      att_st  = StDecay;
    end
  end

  always_comb begin
    dec_env = env_q - Decay_rate;
    dec_st  = StDecay;
    // Compare without underflow: env - rate <= level  <=>  env <= level + rate.
    if ((Decay_rate == EnvZero) ||
        ({1'b0, env_q} <= ({1'b0, Sustain_level} + {1'b0, Decay_rate}))) begin
      dec_env = Sustain_level;
      dec_st  = StSustain;
    end
  end

`ifdef EXP_RELEASE_EN
  logic [ENV_W-1:0] rel_shift;
  logic [ENV_W-5:0] unused_rel_rate;

  assign unused_rel_rate = Release_rate[ENV_W-1:4];

  always_comb begin
    rel_shift = env_q >> Release_rate[3:0];
    rel_dec   = (rel_shift == EnvZero) ? {{(ENV_W-1){1'b0}}, 1'b1} : rel_shift;
  end
`else
  assign rel_dec = Release_rate;
`endif

  always_comb begin
    rel_env = env_q - rel_dec;
    rel_st  = StRelease;
    if ((rel_dec == EnvZero) || (rel_dec >= env_q)) begin
      rel_env = EnvZero;
      rel_st  = StIdle;
    end
  end

  assign prod    = sample_q * $signed({1'b0, env_q});
  assign audio_d = prod[WAVE_W+ENV_W-1:ENV_W];

  logic unused_prod;
  assign unused_prod = ^{prod[WAVE_W+ENV_W], prod[ENV_W-1:0]};

  always_ff @(posedge Sys_clk or posedge Env_rst) begin
    if (Env_rst) begin
      state_q     <= StIdle;
      env_q       <= '0;
      syn_q       <= 1'b0;
      gate_q      <= 1'b0;
      pend_q      <= 1'b0;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sample_q    <= '0;
      audio_q     <= '0;
    end else begin
      syn_q <= Syn_clk;
      if (!Env_ce) begin
        out_valid_q <= 1'b0;
      end else begin
        // Output uses the sample and envelope registered on the previous tick edge.
        out_valid_q <= pend_q;
        if (pend_q) begin
          audio_q <= $signed(audio_d);
        end
        pend_q <= tick;
        if (tick) begin
          gate_q   <= Gate;
          sample_q <= Waveform;
          unique case (state_q)
            StIdle: begin
              if (Gate) begin
                env_q    <= att_env;
                state_q  <= att_st;
                active_q <= 1'b1;
              end
            end
            StAttack, StDecay, StSustain: begin
              if (!Gate) begin
                env_q    <= rel_env;
                state_q  <= rel_st;
                active_q <= (rel_st != StIdle);
              end else if (state_q == StAttack) begin
                env_q   <= att_env;
                state_q <= att_st;
              end else if (state_q == StDecay) begin
                env_q   <= dec_env;
                state_q <= dec_st;
              end else begin
                env_q <= Sustain_level;
              end
            end
            StRelease: begin
              // Retrigger continues from the current level so there is no click.
              if (gate_rise) begin
                env_q    <= att_env;
                state_q  <= att_st;
                active_q <= 1'b1;
              end else begin
                env_q    <= rel_env;
                state_q  <= rel_st;
                active_q <= (rel_st != StIdle);
              end
            end
            default: begin
              env_q    <= '0;
              state_q  <= StIdle;
              active_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign Audio_out = audio_q;
  assign Out_valid = out_valid_q;
  assign Envelope  = env_q;
  assign Active    = active_q;

endmodule

// File: doc/adsr_vca.md
Name: adsr_vca

Overview:
- Downstream of the Oscillator.
- Consumes the signed Waveform sample once per synth-rate tick and generates a per-voice ADSR amplitude envelope.
- Multiplies the sample by the envelope (VCA) and presents the scaled sample to the mixer / AC97 output path.
- Runs entirely in the Sys_clk domain; Syn_clk is treated as a sample-rate strobe and edge-detected.

Parameters:
- WAVE_W, 32, width of signed Waveform in and Audio_out.
- ENV_W, 16, width of unsigned envelope / rate / level values; full scale = 2^ENV_W-1.

Ports:
- Sys_clk  in  1  system clock; all logic on rising edge.
- Env_rst  in  1  asynchronous active-high reset.
- Env_ce  in  1  clock enable. Low: state, envelope and outputs frozen; ticks ignored; Out_valid=0.
- Syn_clk  in  1  sample-rate strobe from Synth_clk; a rising edge = one sample tick.
- Gate  in  1  note on (1) / off (0); sampled only on ticks.
- Attack_rate  in  ENV_W  envelope increment per tick in ATTACK.
- Decay_rate  in  ENV_W  decrement per tick in DECAY.
- Sustain_level  in  ENV_W  sustain target.
- Release_rate  in  ENV_W  decrement per tick in RELEASE.
- Waveform  in  WAVE_W  signed oscillator sample.
- Audio_out  out  WAVE_W  signed scaled sample.
- Out_valid  out  1  one-Sys_clk pulse when Audio_out updates.
- Envelope  out  ENV_W  current envelope value.
- Active  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, Env_rst=1): state=IDLE, Envelope=0, Audio_out=0, Out_valid=0, Active=0, syn_d=0, captured sample=0.
- Tick detection: syn_d registers Syn_clk each cycle; tick = Syn_clk & ~syn_d & Env_ce. A Syn_clk held high yields exactly one tick.
- Edge E (tick=1):
  - state and Envelope update;
  - Waveform is captured;
  - Gate is evaluated.
- Edge E+1: Audio_out = (captured_sample * {0,Envelope_new}) >>> ENV_W. The product is signed WAVE_W+ENV_W+1 bits; take bits [WAVE_W+ENV_W-1:ENV_W] (arithmetic truncation toward -inf). Out_valid=1 for exactly this cycle; 0 otherwise.
- Transitions, evaluated at a tick; Gate edges are judged against Gate at the previous tick:
  - IDLE: Gate=1 -> ATTACK; the env add is applied on the same tick.
  - ATTACK: env += Attack_rate, saturating at full scale. Reaching full scale -> DECAY. Attack_rate=0 -> env=full scale immediately.
  - DECAY: if env - Decay_rate <= Sustain_level (or rate=0), env=Sustain_level -> SUSTAIN. Otherwise env -= Decay_rate.
  - SUSTAIN: env tracks Sustain_level each tick.
  - RELEASE: env -= Release_rate, saturating at 0. Reaching 0 -> IDLE. Release_rate=0 -> env=0 immediately.
  - Gate=0 in ATTACK/DECAY/SUSTAIN -> RELEASE; the release decrement is applied on that tick.
  - Gate=1 rising in RELEASE -> ATTACK from the current env (retrigger without click; no reset to 0).
  - Gate=1 steady while in RELEASE (never dropped again) is impossible; a Gate re-rise while in ATTACK/DECAY/SUSTAIN has no effect.
- Sustain_level above current env in DECAY: the clamp rule applies (env jumps to Sustain_level, -> SUSTAIN).
- Inputs may change at any time; rates and levels are sampled only on ticks.
- Env_ce dropping mid-operation: freeze everything; resume from the same state on the next tick after Env_ce returns high.
- Env_rst mid-note: immediate IDLE, env 0, output 0.

Optional Feature:
- Macro EXP_RELEASE_EN.
- Defined: RELEASE decrement = max(env >> Release_rate[3:0], 1), giving an exponential tail; exit to IDLE at 0.
- Not defined: linear release as above; Release_rate used in full.

Test Plan:
1. Reset, Gate=1, Attack_rate=16384, Decay_rate=8192, Sustain_level=32768 -> Envelope per tick:
   - ATTACK: 16384, 32768, 49152, 65535 (-> DECAY);
   - DECAY: 57343, 49151, 40959, 32768 (-> SUSTAIN).
2. In SUSTAIN at 32768, Waveform=+1000000 -> Audio_out=500000, Out_valid pulse one cycle after the tick edge. Waveform=-1000000 -> -500000.
3. Env forced to 65535 (Attack_rate=65535, first tick), Waveform=32'h7FFFFFFF -> Audio_out=2147450879; Waveform=32'h80000000 -> -2147450880.
4. From SUSTAIN 32768, Gate=0, Release_rate=10000 -> 22768, 12768, 2768, 0; state IDLE; Active falls on that edge. With EXP_RELEASE_EN and Release_rate=1, the first step gives 16384.
5. Gate re-raised at env=12768 in RELEASE, Attack_rate=16384 -> next tick env=29152, state ATTACK.
6. Syn_clk held high for 10 cycles -> single tick. Env_ce=0 across two Syn_clk edges -> no env change, no Out_valid. Env_rst pulse mid-ATTACK -> Envelope, Audio_out, Active = 0 immediately, without waiting for a clock.
